// File: rtl/resampler_pkg.sv
// Shared constants and types for the spectral resampler frame controller.
package resampler_pkg;
    localparam int WIDTH  = 11;
    localparam int SF_W   = 24;
    localparam int N_BINS = 1 << WIDTH;

    // Unsigned Q3.21 unity gain.
    localparam logic [SF_W-1:0]  SF_ONE  = 24'h200000;
    localparam logic [WIDTH-1:0] K_LAST  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] K_PENULT = K_LAST - 1'b1;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RUN  = 1'b1
    } rd_state_t;
endpackage

// File: rtl/resampler_frame_ctrl_if.sv
// FFT ingress, bank write port and read-sweep handshake of the frame controller.
interface resampler_frame_ctrl_if;
    import resampler_pkg::*;

    logic             fft_valid;
    logic             fft_last;
    logic [WIDTH-1:0] fft_user;
    logic [SF_W-1:0]  scale_factor;
    logic             scale_factor_valid;
    logic             wr_en;
    logic             wr_bank;
    logic [WIDTH-1:0] wr_addr;
    logic             rd_valid;
    logic             rd_ready;
    logic             rd_bank;
    logic [WIDTH-1:0] rd_count;
    logic             rd_last;
    logic [SF_W-1:0]  rd_scale;
    logic             frame_drop;
    logic [1:0]       occupancy;

    modport master (
        output fft_valid, fft_last, fft_user, scale_factor, scale_factor_valid, rd_ready,
        input  wr_en, wr_bank, wr_addr, rd_valid, rd_bank, rd_count, rd_last, rd_scale,
               frame_drop, occupancy
    );

    modport slave (
        input  fft_valid, fft_last, fft_user, scale_factor, scale_factor_valid, rd_ready,
        output wr_en, wr_bank, wr_addr, rd_valid, rd_bank, rd_count, rd_last, rd_scale,
               frame_drop, occupancy
    );
endinterface

// File: rtl/resampler_rd_seq.sv
// Read sweep sequencer: walks bin index 0..N-1 of the current read bank under ready/valid.
//
// state  | meaning
// R_IDLE | no sweep; waiting for the read bank to be full
// R_RUN  | sweep active, rd_valid high, cnt is the presented bin index
module resampler_rd_seq
    import resampler_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             rd_ready_i,
    output logic             done_o,
    output logic             rd_valid_o,
    output logic             rd_last_o,
    output logic [WIDTH-1:0] rd_count_o
);
    rd_state_t        state_q;
    logic [WIDTH-1:0] cnt_q;
    logic             valid_q;
    logic             last_q;

    // Sweep FSM with registered handshake outputs; outputs only move on an accepted beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= R_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                R_IDLE: begin
                    if (start_i) begin
                        state_q <= R_RUN;
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                    end
                end
                R_RUN: begin
                    if (rd_ready_i) begin
                        if (cnt_q == K_LAST) begin
                            state_q <= R_IDLE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            cnt_q  <= cnt_q + 1'b1;
                            last_q <= (cnt_q == K_PENULT);
                        end
                    end
                end
                default: state_q <= R_IDLE;
            endcase
        end
    end

    assign done_o     = valid_q & rd_ready_i & last_q;
    assign rd_valid_o = valid_q;
    assign rd_last_o  = last_q;
    assign rd_count_o = cnt_q;
endmodule

// File: rtl/resampler_frame_ctrl.sv
// Ping-pong bank steering, frame drop and per-frame scale latching for the resampler.
module resampler_frame_ctrl
    import resampler_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    resampler_frame_ctrl_if.slave  bus
);
    logic            wp_q;
    logic            rp_q;
    logic [1:0]      full_q;
    logic [1:0]      full_d;
    logic [1:0]      occ_q;
    logic            first_q;
    logic            dropping_q;
    logic            frame_drop_q;
    logic [SF_W-1:0] sf_cur_q;
    logic [SF_W-1:0] sf_bank_q [2];

    logic start_drop;
    logic wr_en;
    logic accept_last;
    logic drop_last;
    logic rd_start;
    logic rd_done;

    assign start_drop  = bus.fft_valid & first_q & full_q[wp_q];
    assign wr_en       = bus.fft_valid & ~full_q[wp_q] & ~dropping_q & ~start_drop;
    assign accept_last = wr_en & bus.fft_last;
    assign drop_last   = bus.fft_valid & bus.fft_last & (dropping_q | start_drop);

    // The registered occupancy lags full by a cycle, giving a freshly filled bank one
    // settle cycle before its sweep starts; a bank already counted starts right away.
    assign rd_start = full_q[rp_q] & (occ_q != 2'd0);

    // Set and clear can hit in the same cycle but always on different banks.
    always_comb begin
        full_d = full_q;
        if (accept_last) full_d[wp_q] = 1'b1;
        if (rd_done)     full_d[rp_q] = 1'b0;
    end

    // Bank pointers, full flags, occupancy and scale factor bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q         <= 1'b0;
            rp_q         <= 1'b0;
            full_q       <= 2'b00;
            occ_q        <= 2'd0;
            sf_cur_q     <= SF_ONE;
            sf_bank_q[0] <= SF_ONE;
            sf_bank_q[1] <= SF_ONE;
        end else begin
            full_q <= full_d;
            occ_q  <= {1'b0, full_q[0]} + {1'b0, full_q[1]};
            if (bus.scale_factor_valid) sf_cur_q <= bus.scale_factor;
            if (accept_last) begin
                sf_bank_q[wp_q] <= bus.scale_factor_valid ? bus.scale_factor : sf_cur_q;
                wp_q            <= ~wp_q;
            end
            if (rd_done) rp_q <= ~rp_q;
        end
    end

    // Frame boundary tracking and whole-frame drop when the target bank is still full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first_q      <= 1'b1;
            dropping_q   <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            frame_drop_q <= drop_last;
            if (bus.fft_valid) first_q <= bus.fft_last;
            if (drop_last) begin
                dropping_q <= 1'b0;
            end else if (start_drop) begin
                dropping_q <= 1'b1;
            end
        end
    end

    resampler_rd_seq u_rd_seq (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (rd_start),
        .rd_ready_i (bus.rd_ready),
        .done_o     (rd_done),
        .rd_valid_o (bus.rd_valid),
        .rd_last_o  (bus.rd_last),
        .rd_count_o (bus.rd_count)
    );

    assign bus.wr_en      = wr_en;
    assign bus.wr_bank    = wp_q;
    assign bus.wr_addr    = bus.fft_user;
    assign bus.rd_bank    = rp_q;
    assign bus.rd_scale   = sf_bank_q[rp_q];
    assign bus.frame_drop = frame_drop_q;
    assign bus.occupancy  = occ_q;
endmodule

// File: doc/resampler_frame_ctrl.md
# resampler_frame_ctrl

Frame-level controller for the spectral resampler. Owns two ping-pong bin-memory banks, steers incoming FFT frames into a free bank, and latches one scale factor per frame. When a bank is full, it runs the 2^WIDTH-bin read sweep (bin index plus valid/last) toward the resampler datapath under a ready/valid handshake. It drops whole frames when both banks are occupied, so the FFT never stalls.

## Interface
- WIDTH, 11: log2 of bins per frame; N = 2^WIDTH
- SF_W, 24: scale factor width, unsigned Q3.21
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- fft_valid  in  1  FFT output beat valid (no backpressure)
- fft_last  in  1  last beat of FFT frame, qualified by fft_valid
- fft_user  in  WIDTH  bin index of current FFT beat
- scale_factor  in  SF_W  pitch scale factor
- scale_factor_valid  in  1  scale_factor update strobe
- wr_en  out  1  bank write enable
- wr_bank  out  1  bank being written
- wr_addr  out  WIDTH  write address (= fft_user)
- rd_valid  out  1  read sweep beat valid
- rd_ready  in  1  downstream accepts beat
- rd_bank  out  1  bank being swept
- rd_count  out  WIDTH  bin index k of current beat
- rd_last  out  1  high with rd_valid on k = N-1
- rd_scale  out  SF_W  scale factor latched for the swept frame
- frame_drop  out  1  one-cycle pulse: a frame was discarded
- occupancy  out  2  number of full banks (0..2)

## Operation
- State: wp, rp (1 bit each); full[1:0]; sf_cur; sf_bank[0..1]; dropping; read FSM {R_IDLE, R_RUN}; cnt.
- sf_cur loads scale_factor on every scale_factor_valid. Reset value is SF_ONE = 24'h200000 (1.0).
- Write path (combinational outputs):
  - wr_en = fft_valid & ~full[wp] & ~dropping & ~start_drop, where start_drop = fft_valid & first beat & full[wp].
  - wr_bank = wp.
  - wr_addr = fft_user.
- Frame start:
  - "First beat" is the first fft_valid after reset or after an fft_last.
  - If full[wp] is set at the first beat, the whole frame is dropped: dropping is set until fft_last inclusive.
  - A bank freed mid-frame does not rescue a dropped frame.
- Accepted fft_last (wr_en & fft_last):
  - full[wp] <= 1, sf_bank[wp] <= sf_cur, wp toggles.
  - If scale_factor_valid is high in the same cycle, the new scale_factor value is latched (bypass).
- Dropped fft_last: frame_drop pulses the next cycle; wp is unchanged; dropping clears.
- Read FSM:
  - R_IDLE: if full[rp], go to R_RUN with cnt = 0.
  - R_RUN: rd_valid = 1, rd_count = cnt, rd_bank = rp, rd_scale = sf_bank[rp].
  - On a beat (rd_valid & rd_ready):
    - cnt < N-1: cnt increments.
    - cnt = N-1: rd_last, full[rp] <= 0, rp toggles, go to R_IDLE.
- Set/clear of full in the same cycle always targets different banks: a set needs full[wp] = 0, a clear needs full[rp] = 1. Both apply.
- occupancy = full[0] + full[1], registered.
- rd_count does not wrap; the sweep ends at N-1.

## Timing
- Reset values: rd_valid, rd_last, frame_drop, wr_en = 0; rd_count = 0; rd_bank = 0; occupancy = 0; rd_scale = SF_ONE; wp = rp = 0; FSM = R_IDLE.
- Reset asserted mid-sweep: sweep aborts immediately and all frames are discarded.
- wr_* have zero latency from the fft_* inputs.
- rd_valid rises 2 cycles after the clock edge sampling an accepted fft_last, when the read side is idle.
- Sweep takes N cycles with rd_ready held high.
- After rd_last is accepted, FSM spends 1 cycle in R_IDLE before the next sweep starts.
- rd_valid, once high, stays high with stable rd_count, rd_bank and rd_scale until accepted.
- frame_drop appears 1 cycle after the dropped fft_last.

## Structure
- Shared package resampler_pkg: WIDTH, SF_W, SF_ONE, and a rd_state_t enum {R_IDLE, R_RUN}.
- Natural sub-module: resampler_rd_seq (read FSM plus counter, with handshake inputs full[rp] and rd_ready, and outputs done/rd_*).
- Bank bookkeeping and the write path stay in the top level.

## Test plan
- One frame (N beats, last on fft_user = N-1), scale_factor 24'h300000 pulsed beforehand, rd_ready = 1 -> wr_bank = 0 throughout; rd_valid 2 cycles after last; rd_count 0..2047; rd_last at 2047; rd_scale = 24'h300000.
- Three back-to-back frames with rd_ready = 0 -> frames 1 and 2 fill banks 0 and 1 (occupancy = 2); frame 3 writes nothing; frame_drop pulses once after its last.
- Sweep with rd_ready toggling 1/0 each cycle -> outputs hold while stalled; sweep ends after 4096 cycles; each k appears exactly once.
- scale_factor_valid in the same cycle as fft_last with 24'h100000 -> that frame's rd_scale = 24'h100000; a later change mid-sweep does not alter rd_scale.
- Frame written to bank 1 while bank 0 is swept (full set and clear in the same cycle) -> both take effect; next sweep has rd_bank = 1.
- reset_n low for 1 cycle at k = 500 -> all outputs return to reset values asynchronously; a following frame starts in bank 0.
